// File: rtl/cory_tap2s_pkg.sv
// rtl/cory_tap2s_pkg.sv - shared state encoding for the tap-to-serial converter
package cory_tap2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/cory_tap2s_shift.sv
// rtl/cory_tap2s_shift.sv - window load/shift register with sample index counter
module cory_tap2s_shift #(
  parameter int N = 8,
  parameter int T = 12,
  parameter int P = 4,
  parameter int W = N * T
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic [N-1:0] sample,
  output logic [P-1:0] idx,
  output logic         wlast
);

  localparam logic [P-1:0] LAST_IDX = P'(T - 1);

  logic [W-1:0] sreg_q, sreg_d;
  logic [P-1:0] idx_q, idx_d;

  // Load wins over shift so a reload on the final sample restarts at index 0.
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (load) begin
      sreg_d = data;
      idx_d  = '0;
    end else if (shift) begin
      sreg_d = sreg_q >> N;
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

  assign sample = sreg_q[N-1:0];
  assign idx    = idx_q;
  assign wlast  = (idx_q == LAST_IDX);

endmodule

// File: rtl/cory_tap2s.sv
// rtl/cory_tap2s.sv - tap window to sample-serial converter under per-line commands
module cory_tap2s
  import cory_tap2s_pkg::*;
#(
  parameter int N = 8,
  parameter int T = 12,
  parameter int R = 11,
  parameter int W = N * T,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cmd_v,
  input  logic [R-1:0] i_cmd_cnt,
  output logic         o_cmd_r,
  input  logic         i_a_v,
  input  logic [W-1:0] i_a_d,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [P-1:0] o_z_idx,
  output logic         o_z_wlast,
  output logic         o_z_last,
  input  logic         i_z_r
);

  state_e       state_q, state_d;
  logic [R-1:0] rem_q, rem_d;

  logic         in_shift;
  logic         sh_wlast;
  logic         wend;
  logic         rem_zero;
  logic         z_fire;
  logic         a_fire;
  logic         cmd_fire;
  logic         sh_shift;

  assign in_shift = (state_q == ST_SHIFT);
  assign rem_zero = (rem_q == '0);
  assign wend     = in_shift & sh_wlast;
  assign z_fire   = in_shift & i_z_r;

  // Ready on the final sample lets the next window or command land with no bubble.
  assign o_a_r    = (state_q == ST_LOAD) | (wend & i_z_r & ~rem_zero);
  assign o_cmd_r  = (state_q == ST_IDLE) | (wend & i_z_r & rem_zero);

  assign a_fire   = i_a_v & o_a_r;
  assign cmd_fire = i_cmd_v & o_cmd_r;
  assign sh_shift = z_fire & ~sh_wlast;

  cory_tap2s_shift #(
    .N(N),
    .T(T),
    .P(P),
    .W(W)
  ) u_shift (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (a_fire),
    .shift  (sh_shift),
    .data   (i_a_d),
    .sample (o_z_d),
    .idx    (o_z_idx),
    .wlast  (sh_wlast)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_d = ST_LOAD;
          rem_d   = i_cmd_cnt;
        end
      end
      ST_LOAD: begin
        if (a_fire) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (z_fire && sh_wlast) begin
          if (!rem_zero) begin
            state_d = a_fire ? ST_SHIFT : ST_LOAD;
          end else if (cmd_fire) begin
            state_d = ST_LOAD;
            rem_d   = i_cmd_cnt;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // rem counts windows still to be loaded; it saturates at zero.
    if (a_fire && !rem_zero) rem_d = rem_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign o_z_v     = in_shift;
  assign o_z_wlast = wend;
  assign o_z_last  = wend & rem_zero;

endmodule
